// File: rtl/risc_pkg.sv
// risc_pkg: shared defaults and the register-file FSM state type
package risc_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

  typedef enum logic {
    CLEAR,
    RUN
  } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-writeback busy bits
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             alloc_i,
  input  logic [AW-1:0]    alloc_addr_i,
  input  logic             wb_i,
  input  logic [AW-1:0]    wb_addr_i,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  // writeback clears its bit, alloc sets after it so alloc wins on a same-address collision
  always_comb begin
    busy_d = busy_q;
    if (wb_i) busy_d[wb_addr_i] = 1'b0;
    if (alloc_i) busy_d[alloc_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // busy register, cleared by reset
  always_ff @(posedge clk) begin
    if (clr_i) busy_q <= '0;
    else busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with clear sweep and busy scoreboard; RF_BYPASS_EN forwards writeback data to same-cycle reads
module regfile_sb
  import risc_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NRD-1:0][AW-1:0]    rs_addr,
  output logic [NRD-1:0][XLEN-1:0]  rs_data,
  output logic [NRD-1:0]            rs_busy,
  input  logic                      alloc_en,
  input  logic [AW-1:0]             alloc_addr,
  output logic                      alloc_ok,
  input  logic                      wb_en,
  input  logic [AW-1:0]             wb_addr,
  input  logic [XLEN-1:0]           wb_data,
  output logic                      wb_err,
  output logic                      init_done
);

  rf_state_e                   state_q, state_d;
  logic [AW-1:0]               idx_q, idx_d;
  logic                        init_done_q, init_done_d;
  logic                        wb_err_q, wb_err_d;
  logic [NREGS-1:0][XLEN-1:0]  regs_q, regs_d;
  logic [NREGS-1:0]            busy;
  logic                        run, wb_act;

  assign run      = state_q == RUN;
  assign wb_act   = run && wb_en && wb_addr != '0;
  assign alloc_ok = run && alloc_en && alloc_addr != '0 && !busy[alloc_addr];

  regfile_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .clk          (clk),
    .clr_i        (reset),
    .alloc_i      (alloc_ok),
    .alloc_addr_i (alloc_addr),
    .wb_i         (wb_act),
    .wb_addr_i    (wb_addr),
    .busy_o       (busy)
  );

  // sweep index advances through CLEAR; the last index hands over to RUN
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    wb_err_d    = wb_act && !busy[wb_addr];
    if (!run) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == AW'(NREGS - 1)) begin
        state_d     = RUN;
        init_done_d = 1'b1;
      end
    end
  end

  // control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      wb_err_q    <= wb_err_d;
    end
  end

  // storage update: sweep zeroing in CLEAR, writeback in RUN, x0 pinned to zero
  always_comb begin
    regs_d = regs_q;
    if (!reset && !run) regs_d[idx_q] = '0;
    if (!reset && wb_act) regs_d[wb_addr] = wb_data;
    regs_d[0] = '0;
  end

  // storage has no reset; contents are zeroed by the sweep
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
`ifdef RF_BYPASS_EN
    logic byp;
    assign byp        = wb_act && rs_addr[p] == wb_addr;
    assign rs_data[p] = !run || rs_addr[p] == '0 ? '0 : byp ? wb_data : regs_q[rs_addr[p]];
    assign rs_busy[p] = run && !byp && busy[rs_addr[p]];
`else
    assign rs_data[p] = !run || rs_addr[p] == '0 ? '0 : regs_q[rs_addr[p]];
    assign rs_busy[p] = run && busy[rs_addr[p]];
`endif
  end

  assign wb_err    = wb_err_q;
  assign init_done = init_done_q;

endmodule
